// File: rtl/bus_access_sequencer.sv
// Data-access sequencer: borrows the shared memory bus from instruction fetch for one
// load/store, tolerates wait states up to MAX_WAIT, then holds the bus one recovery cycle.
module bus_access_sequencer #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MAX_WAIT   = 7
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [WIDTH-1:0]      bus_out,
   output logic                  bus_oe,
   output logic                  mem_we,
   input  logic                  mem_ready,
   input  logic [WIDTH-1:0]      bus_in,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_valid,
   output logic                  timeout,
   output logic                  bus_request,
   output logic                  fetch_suppress
);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StRecover
   } state_e;

   localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

   state_e                state_q, state_d;
   logic [3:0]            wait_q, wait_d;
   logic                  abort_q, abort_d;
   logic                  rd_done_q, rd_done_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic [WIDTH-1:0]      rd_data_q, rd_data_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         wait_q    <= 4'd0;
         abort_q   <= 1'b0;
         rd_done_q <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         abort_q   <= abort_d;
         rd_done_q <= rd_done_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      abort_d        = abort_q;
      rd_done_d      = rd_done_q;
      write_d        = write_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rd_data_d      = rd_data_q;
      req_ready      = 1'b0;
      bus_oe         = 1'b0;
      mem_we         = 1'b0;
      rd_valid       = 1'b0;
      timeout        = 1'b0;
      bus_request    = 1'b0;
      fetch_suppress = 1'b0;

      case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               write_d   = req_write;
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               wait_d    = 4'd0;
               abort_d   = 1'b0;
               rd_done_d = 1'b0;
               state_d   = StAccess;
            end
         end
         StAccess: begin
            bus_request = 1'b1;
            bus_oe      = write_q;
            mem_we      = write_q;
            // Completion is checked before the wait limit so a late ready still wins.
            if (mem_ready) begin
               if (!write_q) begin
                  rd_data_d = bus_in;
               end
               rd_done_d = !write_q;
               state_d   = StRecover;
            end else if (wait_q == MaxWait) begin
               abort_d = 1'b1;
               state_d = StRecover;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         StRecover: begin
            bus_request    = 1'b1;
            fetch_suppress = 1'b1;
            rd_valid       = rd_done_q;
            timeout        = abort_q;
            state_d        = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign addr_out = addr_q;
   assign bus_out  = bus_oe ? wdata_q : '0;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_bus_access_sequencer.sv
// Directed bench for bus_access_sequencer; read results are checked through a scoreboard queue.
module tb_bus_access_sequencer;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic [15:0] addr_out;
   logic [7:0]  bus_out;
   logic        bus_oe;
   logic        mem_we;
   logic        mem_ready;
   logic [7:0]  bus_in;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        timeout;
   logic        bus_request;
   logic        fetch_suppress;

   int          tests;
   int          fails;
   int          cycle;
   logic [7:0]  exp_q[$];

   bus_access_sequencer #(
      .WIDTH     (8),
      .ADDR_WIDTH(16),
      .MAX_WAIT  (7)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .addr_out      (addr_out),
      .bus_out       (bus_out),
      .bus_oe        (bus_oe),
      .mem_we        (mem_we),
      .mem_ready     (mem_ready),
      .bus_in        (bus_in),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .timeout       (timeout),
      .bus_request   (bus_request),
      .fetch_suppress(fetch_suppress)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; sample #1 after the edge, then run the per-cycle scoreboard and invariant.
   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
      chk("req0_fs1_never", 32'(!bus_request && fetch_suppress), 32'd0);
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
         end else begin
            chk("sb_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            chk("sb_no_timeout_with_rd", 32'(timeout), 32'd0);
         end
      end
   endtask

   initial begin
      int n;
      int last_acc;
      tests     = 0;
      fails     = 0;
      cycle     = 0;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 16'h0;
      req_wdata = 8'h0;
      mem_ready = 1'b0;
      bus_in    = 8'h0;

      // Reset
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_bus_request", 32'(bus_request), 32'd0);
      chk("rst_fetch_suppress", 32'(fetch_suppress), 32'd0);
      chk("rst_bus_oe", 32'(bus_oe), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_addr_out", 32'(addr_out), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_bus_out", 32'(bus_out), 32'd0);

      // Single-cycle read of 0x1234
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'h1234;
      tick();
      req_valid = 1'b0;
      mem_ready = 1'b1;
      bus_in    = 8'hA5;
      chk("rd_acc_bus_request", 32'(bus_request), 32'd1);
      chk("rd_acc_fetch_suppress", 32'(fetch_suppress), 32'd0);
      chk("rd_acc_req_ready", 32'(req_ready), 32'd0);
      chk("rd_acc_addr_out", 32'(addr_out), 32'h1234);
      chk("rd_acc_bus_oe", 32'(bus_oe), 32'd0);
      chk("rd_acc_mem_we", 32'(mem_we), 32'd0);
      exp_q.push_back(8'hA5);
      tick();
      mem_ready = 1'b0;
      chk("rd_rec_bus_request", 32'(bus_request), 32'd1);
      chk("rd_rec_fetch_suppress", 32'(fetch_suppress), 32'd1);
      chk("rd_rec_rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_rec_rd_data", 32'(rd_data), 32'hA5);
      tick();
      chk("rd_idle_req_ready", 32'(req_ready), 32'd1);
      chk("rd_idle_bus_request", 32'(bus_request), 32'd0);
      chk("rd_idle_addr_hold", 32'(addr_out), 32'h1234);

      // Write 0x3C to 0x00FF, two wait states
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h00FF;
      req_wdata = 8'h3C;
      tick();
      req_valid = 1'b0;
      req_wdata = 8'h00;
      for (int i = 0; i < 3; i++) begin
         chk("wr_acc_mem_we", 32'(mem_we), 32'd1);
         chk("wr_acc_bus_oe", 32'(bus_oe), 32'd1);
         chk("wr_acc_bus_out", 32'(bus_out), 32'h3C);
         chk("wr_acc_addr_out", 32'(addr_out), 32'h00FF);
         mem_ready = (i == 2);
         tick();
      end
      mem_ready = 1'b0;
      chk("wr_rec_mem_we", 32'(mem_we), 32'd0);
      chk("wr_rec_bus_oe", 32'(bus_oe), 32'd0);
      chk("wr_rec_bus_out", 32'(bus_out), 32'd0);
      chk("wr_rec_rd_valid", 32'(rd_valid), 32'd0);
      chk("wr_rec_timeout", 32'(timeout), 32'd0);
      chk("wr_rec_fetch_suppress", 32'(fetch_suppress), 32'd1);
      tick();

      // Read that never completes: 8 ACCESS cycles then timeout
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'h0042;
      bus_in    = 8'h77;
      tick();
      req_valid = 1'b0;
      n = 0;
      while (bus_request && !fetch_suppress && n < 20) begin
         n++;
         tick();
      end
      chk("to_access_cycles", 32'(n), 32'd8);
      chk("to_timeout", 32'(timeout), 32'd1);
      chk("to_rd_valid", 32'(rd_valid), 32'd0);
      chk("to_rd_data_kept", 32'(rd_data), 32'hA5);
      tick();
      chk("to_pulse_one_cycle", 32'(timeout), 32'd0);

      // Ready arrives exactly when the counter reaches MAX_WAIT
      req_valid = 1'b1;
      req_addr  = 16'h0100;
      bus_in    = 8'h5A;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
      end
      chk("edge_still_access", 32'(bus_request && !fetch_suppress), 32'd1);
      mem_ready = 1'b1;
      exp_q.push_back(8'h5A);
      tick();
      mem_ready = 1'b0;
      chk("edge_rd_valid", 32'(rd_valid), 32'd1);
      chk("edge_timeout", 32'(timeout), 32'd0);
      tick();

      // Back-to-back requests: accepts exactly 3 cycles apart
      req_valid = 1'b1;
      mem_ready = 1'b1;
      bus_in    = 8'h11;
      last_acc  = -1;
      for (int i = 0; i < 12; i++) begin
         if (req_valid && req_ready) begin
            if (last_acc >= 0) begin
               chk("b2b_accept_spacing", 32'(cycle - last_acc), 32'd3);
            end
            last_acc = cycle;
            exp_q.push_back(bus_in);
         end
         req_addr = 16'(16'h2000 + i);
         tick();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      mem_ready = 1'b0;
      chk("b2b_drained", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a read
      req_valid = 1'b1;
      req_addr  = 16'hBEEF;
      tick();
      req_valid = 1'b0;
      tick();
      chk("mid_pre_access", 32'(bus_request), 32'd1);
      reset_n = 1'b0;
      tick();
      chk("mid_bus_request", 32'(bus_request), 32'd0);
      chk("mid_fetch_suppress", 32'(fetch_suppress), 32'd0);
      chk("mid_bus_oe", 32'(bus_oe), 32'd0);
      chk("mid_mem_we", 32'(mem_we), 32'd0);
      chk("mid_rd_valid", 32'(rd_valid), 32'd0);
      chk("mid_timeout", 32'(timeout), 32'd0);
      chk("mid_addr_out", 32'(addr_out), 32'd0);
      chk("mid_rd_data", 32'(rd_data), 32'd0);
      chk("mid_req_ready", 32'(req_ready), 32'd1);
      reset_n = 1'b1;
      tick();
      chk("mid_post_rd_valid", 32'(rd_valid), 32'd0);
      chk("mid_post_timeout", 32'(timeout), 32'd0);
      tick();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
